// File: rtl/cobs_vram_writer.sv
// COBS frame decoder feeding VRAM pixel writes over a req/ack port to the SDRAM arbiter.
// Each frame starts with a command byte, followed by pixel data or address pairs.
module cobs_vram_writer #(
    parameter int unsigned ADDR_W   = 16,
    parameter logic [7:0]  CMD_DATA = 8'h01,
    parameter logic [7:0]  CMD_ADDR = 8'h02
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ack,
    input  logic              err_clr,
    output logic              frame_err,
    output logic              overrun
);

    typedef enum logic [2:0] {
        StCmd,
        StData,
        StAlo,
        StAhi,
        StSkip
    } cmd_state_e;

    cmd_state_e        cmd_q, cmd_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              zero_pend_q, zero_pend_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              wr_req_q, wr_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic              dec_valid;
    logic [7:0]        dec_byte;

    always_comb begin
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        zero_pend_d = zero_pend_q;
        next_addr_d = next_addr_q;
        wr_req_d    = wr_req_q & ~wr_ack;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q & ~err_clr;
        dec_valid   = 1'b0;
        dec_byte    = rx_data;

        // COBS layer: at most one decoded byte per raw byte
        if (rx_valid) begin
            if (rx_data == 8'h00) begin
                if (cnt_q != 8'h00) begin
                    frame_err_d = 1'b1;
                end
                cnt_d       = 8'h00;
                zero_pend_d = 1'b0;
                cmd_d       = StCmd;
            end else if (cnt_q == 8'h00) begin
                cnt_d       = rx_data - 8'd1;
                zero_pend_d = (rx_data != 8'hFF);
                if (zero_pend_q) begin
                    dec_valid = 1'b1;
                    dec_byte  = 8'h00;
                end
            end else begin
                dec_valid = 1'b1;
                cnt_d     = cnt_q - 8'd1;
            end
        end

        if (dec_valid) begin
            case (cmd_q)
                StCmd: begin
                    if (dec_byte == CMD_DATA) begin
                        cmd_d = StData;
                    end else if (dec_byte == CMD_ADDR) begin
                        cmd_d = StAlo;
                    end else begin
                        frame_err_d = 1'b1;
                        cmd_d       = StSkip;
                    end
                end
                StData: begin
                    // A pending unacked request keeps its addr/data; the byte is lost
                    if (!wr_req_q || wr_ack) begin
                        wr_req_d  = 1'b1;
                        wr_addr_d = next_addr_q;
                        wr_data_d = dec_byte;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    next_addr_d = next_addr_q + ADDR_W'(1);
                end
                StAlo: begin
                    next_addr_d[7:0] = dec_byte;
                    cmd_d            = StAhi;
                end
                StAhi: begin
                    next_addr_d[ADDR_W-1:8] = dec_byte[ADDR_W-9:0];
                    cmd_d                   = StAlo;
                end
                StSkip: begin
                    cmd_d = StSkip;
                end
                default: begin
                    cmd_d = StCmd;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= StCmd;
            cnt_q       <= 8'h00;
            zero_pend_q <= 1'b0;
            next_addr_q <= '0;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            zero_pend_q <= zero_pend_d;
            next_addr_q <= next_addr_d;
            wr_req_q    <= wr_req_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign wr_req    = wr_req_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cobs_vram_writer.sv
// Bench for cobs_vram_writer: directed scenarios plus random frames checked against a
// payload-level model (COBS-encode in bench, expected writes derived from the raw payload).
module tb_cobs_vram_writer;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        err_clr;
    logic        frame_err;
    logic        overrun;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          ferr_seen;
    logic [15:0] m_addr;
    logic [23:0] exp_q[$];

    cobs_vram_writer dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .err_clr   (err_clr),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic bq_t cobs_encode(input bq_t pl);
        bq_t        out;
        int         ci;
        logic [7:0] code;
        out = {};
        out.push_back(8'h00);
        ci   = 0;
        code = 8'h01;
        foreach (pl[i]) begin
            if (pl[i] == 8'h00) begin
                out[ci] = code;
                ci      = out.size();
                out.push_back(8'h00);
                code = 8'h01;
            end else begin
                out.push_back(pl[i]);
                code = code + 8'd1;
                if (code == 8'hFF) begin
                    out[ci] = code;
                    ci      = out.size();
                    out.push_back(8'h00);
                    code = 8'h01;
                end
            end
        end
        out[ci] = code;
        out.push_back(8'h00);
        return out;
    endfunction

    // Payload semantics: first byte is the command, the rest are pixels or {lo,hi} pairs
    task automatic model_frame(input bq_t pl, output int err);
        err = 0;
        if (pl.size() == 0) return;
        if (pl[0] == 8'h01) begin
            for (int i = 1; i < pl.size(); i++) begin
                exp_q.push_back({m_addr, pl[i]});
                m_addr = m_addr + 16'd1;
            end
        end else if (pl[0] == 8'h02) begin
            for (int i = 1; i < pl.size(); i++) begin
                if (i % 2 == 1) m_addr[7:0] = pl[i];
                else            m_addr[15:8] = pl[i];
            end
        end else begin
            err = 1;
        end
    endtask

    task automatic send_raw(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Sends one raw byte and services any write it produces with a random ack delay
    task automatic send(input logic [7:0] b);
        logic [23:0] e;
        send_raw(b);
        if (frame_err) ferr_seen++;
        if (wr_req) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'h1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'h0;
            check("wr_addr", 32'(wr_addr), 32'(e[23:8]));
            check("wr_data", 32'(wr_data), 32'(e[7:0]));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("hold_req", 32'(wr_req), 32'h1);
                check("hold_addr_data", {8'h0, wr_addr, wr_data}, {8'h0, e});
            end
            wr_ack = 1'b1;
            @(negedge clk);
            wr_ack = 1'b0;
            check("req_drop_after_ack", 32'(wr_req), 32'h0);
        end
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic send_bytes(input bq_t raw, input int exp_err);
        ferr_seen = 0;
        foreach (raw[i]) send(raw[i]);
        check("frame_err_count", 32'(ferr_seen), 32'(exp_err));
        check("writes_outstanding", 32'(exp_q.size()), 32'h0);
        exp_q = {};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_addr = 16'h0000;
        exp_q = {};
    endtask

    initial begin
        bq_t pl;
        int  err;
        int  kind;
        logic [7:0] c;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        wr_ack   = 1'b0;
        err_clr  = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();
        check("reset_outputs", {29'h0, wr_req, frame_err, overrun}, 32'h0);
        check("reset_addr_data", {8'h0, wr_addr, wr_data}, 32'h0);

        // Two pixels from address 0
        model_frame({8'h01, 8'hAA, 8'hBB}, err);
        send_bytes({8'h04, 8'h01, 8'hAA, 8'hBB, 8'h00}, 0);

        // Address set then single pixel
        model_frame({8'h02, 8'h34, 8'h12}, err);
        send_bytes({8'h04, 8'h02, 8'h34, 8'h12, 8'h00}, 0);
        model_frame({8'h01, 8'h55}, err);
        send_bytes({8'h03, 8'h01, 8'h55, 8'h00}, 0);

        // Embedded zero
        model_frame({8'h01, 8'h11, 8'h00, 8'h22}, err);
        send_bytes({8'h03, 8'h01, 8'h11, 8'h02, 8'h22, 8'h00}, 0);

        // Truncated frame: pixel written, error at delimiter
        exp_q.push_back({m_addr, 8'hAA});
        m_addr = m_addr + 16'd1;
        send_bytes({8'h05, 8'h01, 8'hAA, 8'h00}, 1);
        model_frame({8'h07}, err);
        send_bytes({8'h02, 8'h07, 8'h00}, err);

        // Overrun with ack held low
        do_reset();
        send_raw(8'h04);
        send_raw(8'h01);
        send_raw(8'hA1);
        send_raw(8'hA2);
        send_raw(8'h00);
        check("ovr_req_held", 32'(wr_req), 32'h1);
        check("ovr_addr_data", {8'h0, wr_addr, wr_data}, {8'h0, 16'h0000, 8'hA1});
        check("ovr_flag", 32'(overrun), 32'h1);
        m_addr = 16'h0002;
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        check("ovr_req_released", 32'(wr_req), 32'h0);
        model_frame({8'h01, 8'hB0}, err);
        check("ovr_b0_addr_model", 32'(exp_q[0][23:8]), 32'h0002);
        send_bytes({8'h03, 8'h01, 8'hB0, 8'h00}, 0);
        check("ovr_sticky", 32'(overrun), 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);

        // Address wrap, then reset mid-frame and resync
        model_frame({8'h02, 8'hFF, 8'hFF}, err);
        send_bytes(cobs_encode({8'h02, 8'hFF, 8'hFF}), 0);
        exp_q.push_back({16'hFFFF, 8'hC1});
        exp_q.push_back({16'h0000, 8'hC2});
        m_addr = 16'h0001;
        send_bytes({8'h04, 8'h01, 8'hC1, 8'hC2, 8'h00}, 0);
        send_raw(8'h03);
        send_raw(8'h01);
        send_raw(8'hD0);
        check("mid_req_pending", 32'(wr_req), 32'h1);
        do_reset();
        check("mid_reset_req", {30'h0, wr_req, overrun}, 32'h0);
        send_bytes({8'h00}, 0);
        model_frame({8'h01, 8'hE0}, err);
        send_bytes(cobs_encode({8'h01, 8'hE0}), 0);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            pl   = {};
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                pl.push_back(8'h01);
                repeat ($urandom_range(0, 20)) begin
                    if ($urandom_range(0, 3) == 0) pl.push_back(8'h00);
                    else pl.push_back(8'($urandom_range(0, 255)));
                end
            end else if (kind == 6) begin
                pl.push_back(8'h01);
                repeat ($urandom_range(250, 300)) pl.push_back(8'($urandom_range(1, 255)));
            end else if (kind == 7) begin
                pl.push_back(8'h02);
                repeat ($urandom_range(1, 4)) pl.push_back(8'($urandom_range(0, 255)));
            end else if (kind == 8) begin
                c = 8'($urandom_range(0, 255));
                while (c == 8'h01 || c == 8'h02) c = 8'($urandom_range(0, 255));
                pl.push_back(c);
                repeat ($urandom_range(0, 5)) pl.push_back(8'($urandom_range(0, 255)));
            end
            model_frame(pl, err);
            send_bytes(cobs_encode(pl), err);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
